// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the EX-stage decoder and the multiply/divide unit.
// The decoder side is the master; ex_muldiv is the slave.
interface ex_muldiv_if #(
    parameter int XLEN = 32
);
    logic            rdy;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd_in;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] rd_data_o;
    logic [4:0]      rd_addr;
    logic            ex_stall;

    modport master (
        output rdy, flush, in_valid, op, rs1_val, rs2_val, rd_in, out_ready,
        input  in_ready, out_valid, rd_data_o, rd_addr, ex_stall
    );

    modport slave (
        input  rdy, flush, in_valid, op, rs1_val, rs2_val, rd_in, out_ready,
        output in_ready, out_valid, rd_data_o, rd_addr, ex_stall
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, retiring UNROLL bits per cycle, with sign fix-up on the last step.
module ex_muldiv #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic       clk,
    input  logic       rst,
    ex_muldiv_if.slave bus
);
    localparam int STEPS = XLEN / UNROLL;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_next;

    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [2*XLEN-1:0] acc, mcand;
    logic [XLEN-1:0]   mplier, quo, rem, divisor;
    logic [XLEN-1:0]   rd_data_q;
    logic [4:0]        rd_addr_q;

    logic              is_div, a_signed, b_signed, a_neg, b_neg;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   mag_a, mag_b, special_res;

    // Operand decode at acceptance; special divides are answered without iterating.
    always_comb begin
        is_div   = bus.op[2];
        a_signed = is_div ? !bus.op[0] : (bus.op[1:0] != 2'b11);
        b_signed = is_div ? !bus.op[0] : !bus.op[1];
        a_neg    = a_signed & bus.rs1_val[XLEN-1];
        b_neg    = b_signed & bus.rs2_val[XLEN-1];
        mag_a    = a_neg ? -bus.rs1_val : bus.rs1_val;
        mag_b    = b_neg ? -bus.rs2_val : bus.rs2_val;
        div_zero = is_div && (bus.rs2_val == '0);
        div_ovf  = is_div && !bus.op[0] && (bus.rs1_val == SMIN) && (bus.rs2_val == '1);
        special  = div_zero || div_ovf;
        if (bus.op[1]) special_res = div_zero ? bus.rs1_val : '0;
        else           special_res = div_zero ? '1 : SMIN;
    end

    logic [2*XLEN-1:0] acc_n, mcand_n, prod;
    logic [XLEN-1:0]   mplier_n, quo_n, rem_n, result;
    logic [XLEN:0]     trial;

    always_comb begin
        acc_n    = acc;
        mcand_n  = mcand;
        mplier_n = mplier;
        quo_n    = quo;
        rem_n    = rem;
        trial    = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (mplier_n[0]) acc_n = acc_n + mcand_n;
            mcand_n  = mcand_n << 1;
            mplier_n = mplier_n >> 1;
            trial    = {rem_n, quo_n[XLEN-1]};
            quo_n    = quo_n << 1;
            if (trial >= {1'b0, divisor}) begin
                trial    = trial - {1'b0, divisor};
                quo_n[0] = 1'b1;
            end
            rem_n = trial[XLEN-1:0];
        end
        prod   = neg_q ? -acc_n : acc_n;
        result = '0;
        case (op_q)
            3'd0:             result = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: result = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       result = neg_q ? -quo_n : quo_n;
            default:          result = neg_q ? -rem_n : rem_n;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bus.in_ready  = (state == IDLE);
        bus.ex_stall  = (state != IDLE);
        bus.out_valid = (state == DONE);
        if (bus.rdy) begin
            if (bus.flush) begin
                state_next = IDLE;
            end else begin
                case (state)
                    IDLE:    if (bus.in_valid) state_next = special ? DONE : CALC;
                    CALC:    if (cnt == CW'(1)) state_next = DONE;
                    DONE:    if (bus.out_ready) state_next = IDLE;
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // Remainder takes the dividend's sign; everything else the xor of both signs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            quo       <= '0;
            rem       <= '0;
            divisor   <= '0;
            rd_data_q <= '0;
            rd_addr_q <= '0;
        end else if (bus.rdy && !bus.flush) begin
            if (state == IDLE && bus.in_valid) begin
                op_q      <= bus.op;
                neg_q     <= (is_div && bus.op[1]) ? a_neg : (a_neg ^ b_neg);
                acc       <= '0;
                mcand     <= {{XLEN{1'b0}}, mag_a};
                mplier    <= mag_b;
                quo       <= mag_a;
                rem       <= '0;
                divisor   <= mag_b;
                cnt       <= CW'(STEPS);
                rd_addr_q <= bus.rd_in;
                if (special) rd_data_q <= special_res;
            end else if (state == CALC) begin
                acc    <= acc_n;
                mcand  <= mcand_n;
                mplier <= mplier_n;
                quo    <= quo_n;
                rem    <= rem_n;
                cnt    <= cnt - CW'(1);
                if (cnt == CW'(1)) rd_data_q <= result;
            end
        end
    end

    assign bus.rd_data_o = rd_data_q;
    assign bus.rd_addr   = rd_addr_q;
endmodule
